// File: rtl/ta_calc.sv
// Sixteen-bit, 8-deep stack calculator driven by one command word per clock.
// Sticky error flags freeze the stack until a done command closes the calculation.
module ta_calc (
  input  logic        ck,
  input  logic        rst_l,
  input  logic [19:0] data,
  output logic [15:0] result,
  output logic        stackOverflow,
  output logic        dataOverflow,
  output logic        protocolError,
  output logic        unexpectedDone,
  output logic        finished,
  output logic        correct
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [3:0] OP_IDLE  = 4'h0;
  localparam logic [3:0] OP_START = 4'h1;
  localparam logic [3:0] OP_ENTER = 4'h2;
  localparam logic [3:0] OP_ARITH = 4'h4;
  localparam logic [3:0] OP_DONE  = 4'h8;

  state_t      state_q, state_d;
  logic [15:0] stk_q [8];
  logic [15:0] stk_d [8];
  logic [3:0]  depth_q, depth_d;
  logic [15:0] result_q, result_d;
  logic        so_q, so_d, do_q, do_d, pe_q, pe_d, ud_q, ud_d;

  logic [3:0]  op;
  logic [15:0] pay, t_val, n_val, sum, diff, neg, new_top;
  logic [2:0]  tidx, nidx;
  logic        sticky, upd;

  assign op     = data[19:16];
  assign pay    = data[15:0];
  assign sticky = so_q | do_q | pe_q;
  assign tidx   = depth_q[2:0] - 3'd1;
  assign nidx   = depth_q[2:0] - 3'd2;
  assign t_val  = stk_q[tidx];
  assign n_val  = stk_q[nidx];
  assign sum    = n_val + t_val;
  assign diff   = n_val - t_val;
  assign neg    = 16'd0 - t_val;

  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    so_d    = so_q;
    do_d    = do_q;
    pe_d    = pe_q;
    ud_d    = 1'b0;
    upd     = 1'b0;
    for (int i = 0; i < 8; i++) stk_d[i] = stk_q[i];

    if (op == OP_DONE) begin
      state_d = IDLE;
      depth_d = 4'd0;
      so_d    = 1'b0;
      do_d    = 1'b0;
      pe_d    = 1'b0;
      ud_d    = (depth_q != 4'd1);
    end else if (op != OP_IDLE && !sticky) begin
      case (op)
        OP_START: begin
          if (state_q == IDLE) begin
            for (int i = 0; i < 8; i++) stk_d[i] = 16'd0;
            stk_d[0] = pay;
            depth_d  = 4'd1;
            state_d  = ACTIVE;
            upd      = 1'b1;
          end else pe_d = 1'b1;
        end
        OP_ENTER: begin
          if (state_q == IDLE) pe_d = 1'b1;
          else if (depth_q == 4'd8) so_d = 1'b1;
          else begin
            stk_d[depth_q[2:0]] = pay;
            depth_d = depth_q + 4'd1;
            upd     = 1'b1;
          end
        end
        OP_ARITH: begin
          if (state_q == IDLE) pe_d = 1'b1;
          else begin
            case (pay)
              16'h0001, 16'h0002, 16'h0004, 16'h0008: begin
                if (depth_q < 4'd2) pe_d = 1'b1;
                else begin
                  upd = 1'b1;
                  if (pay == 16'h0008) begin
                    stk_d[tidx] = n_val;
                    stk_d[nidx] = t_val;
                  end else begin
                    depth_d = depth_q - 4'd1;
                    if (pay == 16'h0001) begin
                      stk_d[nidx] = sum;
                      do_d = (n_val[15] == t_val[15]) && (sum[15] != n_val[15]);
                    end else if (pay == 16'h0002) begin
                      stk_d[nidx] = diff;
                      do_d = (n_val[15] != t_val[15]) && (diff[15] != n_val[15]);
                    end else stk_d[nidx] = n_val & t_val;
                  end
                end
              end
              16'h0010: begin
                if (depth_q < 4'd1) pe_d = 1'b1;
                else begin
                  stk_d[tidx] = neg;
                  do_d = (t_val == 16'h8000);
                  upd  = 1'b1;
                end
              end
              16'h0020: begin
                if (depth_q < 4'd1) pe_d = 1'b1;
                else begin
                  depth_d = depth_q - 4'd1;
                  upd     = 1'b1;
                end
              end
              default: pe_d = 1'b1;
            endcase
          end
        end
        default: pe_d = 1'b1;
      endcase
    end
  end

  // result only tracks the stack when it actually changes, so it holds across done
  assign new_top  = stk_d[depth_d[2:0] - 3'd1];
  assign result_d = !upd ? result_q : (depth_d == 4'd0) ? 16'd0 : new_top;

  always_ff @(posedge ck) begin
    if (rst_l) begin
      state_q  <= IDLE;
      depth_q  <= 4'd0;
      result_q <= 16'd0;
      so_q     <= 1'b0;
      do_q     <= 1'b0;
      pe_q     <= 1'b0;
      ud_q     <= 1'b0;
      for (int i = 0; i < 8; i++) stk_q[i] <= 16'd0;
    end else begin
      state_q  <= state_d;
      depth_q  <= depth_d;
      result_q <= result_d;
      so_q     <= so_d;
      do_q     <= do_d;
      pe_q     <= pe_d;
      ud_q     <= ud_d;
      for (int i = 0; i < 8; i++) stk_q[i] <= stk_d[i];
    end
  end

  assign result         = result_q;
  assign stackOverflow  = so_q;
  assign dataOverflow   = do_q;
  assign protocolError  = pe_q;
  assign unexpectedDone = ud_q;
  assign finished       = (op == OP_DONE);
  assign correct        = finished && !sticky && (depth_q == 4'd1);

endmodule

// File: tb/tb_ta_calc.sv
// Scoreboard bench for ta_calc: each command pushes the expected registered
// outputs; a monitor pops and compares them after the following rising edge.
module tb_ta_calc;
  logic        ck = 1'b0;
  logic        rst_l = 1'b1;
  logic [19:0] data = 20'd0;
  logic [15:0] result;
  logic        stackOverflow, dataOverflow, protocolError, unexpectedDone, finished, correct;

  int checks = 0;
  int errors = 0;
  string cur_test = "none";

  localparam logic [3:0] ST = 4'h1, EN = 4'h2, AR = 4'h4, DN = 4'h8, NOP = 4'h0;
  // flag vector order: {stackOverflow, dataOverflow, protocolError, unexpectedDone}
  localparam logic [3:0] F0 = 4'b0000, FSO = 4'b1000, FDO = 4'b0100, FPE = 4'b0010, FUD = 4'b0001;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  flg;
  } exp_t;
  exp_t sb[$];

  ta_calc dut (
    .ck(ck), .rst_l(rst_l), .data(data), .result(result),
    .stackOverflow(stackOverflow), .dataOverflow(dataOverflow),
    .protocolError(protocolError), .unexpectedDone(unexpectedDone),
    .finished(finished), .correct(correct)
  );

  always #5 ck = ~ck;

  always @(posedge ck) begin
    exp_t e;
    logic [3:0] act;
    #2;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      act = {stackOverflow, dataOverflow, protocolError, unexpectedDone};
      checks++;
      if (result !== e.res || act !== e.flg) begin
        errors++;
        $display("FAIL %s: result=%h flags=%b, expected result=%h flags=%b",
                 cur_test, result, act, e.res, e.flg);
      end
    end
  end

  // Drive one command; check the combinational outputs, queue the post-edge expectation.
  task automatic cmd(input logic [3:0] op, input logic [15:0] pay, input logic ecor,
                     input logic [15:0] eres, input logic [3:0] eflg);
    exp_t e;
    @(negedge ck);
    data = {op, pay};
    #1;
    checks++;
    if (finished !== (op == DN) || correct !== ecor) begin
      errors++;
      $display("FAIL %s comb: finished=%b correct=%b, expected finished=%b correct=%b",
               cur_test, finished, correct, (op == DN), ecor);
    end
    e.res = eres;
    e.flg = eflg;
    sb.push_back(e);
  endtask

  task automatic drain();
    @(negedge ck);
    data = 20'd0;
    @(negedge ck);
  endtask

  task automatic test_reset();
    cur_test = "reset";
    @(negedge ck);
    rst_l = 1'b1;
    data = 20'd0;
    @(negedge ck);
    @(negedge ck);
    rst_l = 1'b0;
    checks++;
    if (result !== 16'd0 || {stackOverflow, dataOverflow, protocolError, unexpectedDone} !== 4'b0) begin
      errors++;
      $display("FAIL reset: result=%h flags=%b, expected 0000/0000", result,
               {stackOverflow, dataOverflow, protocolError, unexpectedDone});
    end
  endtask

  task automatic test_add();
    cur_test = "add";
    cmd(ST, 16'd3, 1'b0, 16'd3, F0);
    cmd(EN, 16'd5, 1'b0, 16'd5, F0);
    cmd(AR, 16'h01, 1'b0, 16'd8, F0);
    cmd(DN, 16'd0, 1'b1, 16'd8, F0);
    cmd(NOP, 16'd0, 1'b0, 16'd8, F0);
    drain();
  endtask

  task automatic test_sub_and_swap();
    cur_test = "sub";
    cmd(ST, 16'd10, 1'b0, 16'd10, F0);
    cmd(EN, 16'd4, 1'b0, 16'd4, F0);
    cmd(AR, 16'h02, 1'b0, 16'd6, F0);
    cmd(DN, 16'd0, 1'b1, 16'd6, F0);
    cur_test = "and";
    cmd(ST, 16'd7, 1'b0, 16'd7, F0);
    cmd(EN, 16'd15, 1'b0, 16'd15, F0);
    cmd(AR, 16'h04, 1'b0, 16'd7, F0);
    cmd(DN, 16'd0, 1'b1, 16'd7, F0);
    cur_test = "swap_pop";
    cmd(ST, 16'd9, 1'b0, 16'd9, F0);
    cmd(EN, 16'd10, 1'b0, 16'd10, F0);
    cmd(AR, 16'h08, 1'b0, 16'd9, F0);
    cmd(AR, 16'h20, 1'b0, 16'd10, F0);
    cmd(DN, 16'd0, 1'b1, 16'd10, F0);
    drain();
  endtask

  task automatic test_negate_pop_empty();
    cur_test = "negate";
    cmd(ST, 16'd10, 1'b0, 16'd10, F0);
    cmd(AR, 16'h10, 1'b0, 16'hFFF6, F0);
    cmd(DN, 16'd0, 1'b1, 16'hFFF6, F0);
    cur_test = "pop_empty_done";
    cmd(ST, 16'd15, 1'b0, 16'd15, F0);
    cmd(AR, 16'h20, 1'b0, 16'd0, F0);
    cmd(DN, 16'd0, 1'b0, 16'd0, FUD);
    cmd(NOP, 16'd0, 1'b0, 16'd0, F0);
    drain();
  endtask

  task automatic test_stack_overflow();
    cur_test = "stack_overflow";
    cmd(ST, 16'd1, 1'b0, 16'd1, F0);
    for (int i = 0; i < 7; i++) cmd(EN, 16'd1, 1'b0, 16'd1, F0);
    cmd(EN, 16'd1, 1'b0, 16'd1, FSO);
    cmd(EN, 16'd2, 1'b0, 16'd1, FSO);
    cmd(DN, 16'd0, 1'b0, 16'd1, FUD);
    cmd(NOP, 16'd0, 1'b0, 16'd1, F0);
    cur_test = "full_then_pops";
    cmd(ST, 16'hFFFF, 1'b0, 16'hFFFF, F0);
    for (int i = 0; i < 7; i++) cmd(EN, 16'hFFFF, 1'b0, 16'hFFFF, F0);
    for (int i = 0; i < 7; i++) cmd(AR, 16'h20, 1'b0, 16'hFFFF, F0);
    cmd(DN, 16'd0, 1'b1, 16'hFFFF, F0);
    drain();
  endtask

  task automatic test_data_overflow();
    cur_test = "sub_overflow";
    cmd(ST, 16'h8000, 1'b0, 16'h8000, F0);
    cmd(EN, 16'h0001, 1'b0, 16'h0001, F0);
    cmd(AR, 16'h02, 1'b0, 16'h7FFF, FDO);
    cmd(EN, 16'h0005, 1'b0, 16'h7FFF, FDO);
    cmd(DN, 16'd0, 1'b0, 16'h7FFF, F0);
    cur_test = "add_overflow_pos";
    cmd(ST, 16'h7FFF, 1'b0, 16'h7FFF, F0);
    cmd(EN, 16'h0001, 1'b0, 16'h0001, F0);
    cmd(AR, 16'h01, 1'b0, 16'h8000, FDO);
    cmd(DN, 16'd0, 1'b0, 16'h8000, F0);
    cur_test = "add_overflow_neg";
    cmd(ST, 16'h8000, 1'b0, 16'h8000, F0);
    cmd(EN, 16'h8000, 1'b0, 16'h8000, F0);
    cmd(AR, 16'h01, 1'b0, 16'h0000, FDO);
    cmd(DN, 16'd0, 1'b0, 16'h0000, F0);
    cur_test = "sub_no_overflow";
    cmd(ST, 16'h8000, 1'b0, 16'h8000, F0);
    cmd(EN, 16'h8000, 1'b0, 16'h8000, F0);
    cmd(AR, 16'h02, 1'b0, 16'h0000, F0);
    cmd(DN, 16'd0, 1'b1, 16'h0000, F0);
    cur_test = "negate_min";
    cmd(ST, 16'h8000, 1'b0, 16'h8000, F0);
    cmd(AR, 16'h10, 1'b0, 16'h8000, FDO);
    cmd(DN, 16'd0, 1'b0, 16'h8000, F0);
    drain();
  endtask

  task automatic test_protocol();
    cur_test = "double_start";
    cmd(ST, 16'd7, 1'b0, 16'd7, F0);
    cmd(EN, 16'd2, 1'b0, 16'd2, F0);
    cmd(ST, 16'd7, 1'b0, 16'd2, FPE);
    cmd(EN, 16'd3, 1'b0, 16'd2, FPE);
    cmd(DN, 16'd0, 1'b0, 16'd2, FUD);
    cmd(NOP, 16'd0, 1'b0, 16'd2, F0);
    cur_test = "bad_arith";
    cmd(ST, 16'd1, 1'b0, 16'd1, F0);
    cmd(AR, 16'h12, 1'b0, 16'd1, FPE);
    cmd(DN, 16'd0, 1'b0, 16'd1, F0);
    cur_test = "underflow";
    cmd(ST, 16'd1, 1'b0, 16'd1, F0);
    cmd(EN, 16'd2, 1'b0, 16'd2, F0);
    cmd(AR, 16'h01, 1'b0, 16'd3, F0);
    cmd(AR, 16'h01, 1'b0, 16'd3, FPE);
    cmd(DN, 16'd0, 1'b0, 16'd3, F0);
    cur_test = "idle_enter";
    cmd(EN, 16'd4, 1'b0, 16'd3, FPE);
    cmd(DN, 16'd0, 1'b0, 16'd3, FUD);
    cur_test = "bad_opcode";
    cmd(ST, 16'd6, 1'b0, 16'd6, F0);
    cmd(4'h3, 16'd0, 1'b0, 16'd6, FPE);
    cmd(DN, 16'd0, 1'b0, 16'd6, F0);
    cur_test = "nop_no_error";
    cmd(NOP, 16'hFFFF, 1'b0, 16'd6, F0);
    drain();
  endtask

  task automatic test_mid_reset();
    cur_test = "mid_reset";
    cmd(ST, 16'd5, 1'b0, 16'd5, F0);
    cmd(EN, 16'd6, 1'b0, 16'd6, F0);
    drain();
    @(negedge ck);
    rst_l = 1'b1;
    data = {ST, 16'd9};
    @(negedge ck);
    rst_l = 1'b0;
    data = 20'd0;
    checks++;
    if (result !== 16'd0 || {stackOverflow, dataOverflow, protocolError, unexpectedDone} !== 4'b0) begin
      errors++;
      $display("FAIL mid_reset: result=%h flags=%b, expected 0000/0000", result,
               {stackOverflow, dataOverflow, protocolError, unexpectedDone});
    end
    cmd(EN, 16'd1, 1'b0, 16'd0, FPE);
    cmd(DN, 16'd0, 1'b0, 16'd0, FUD);
    drain();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_and_swap();
    test_negate_pop_empty();
    test_stack_overflow();
    test_data_overflow();
    test_protocol();
    test_mid_reset();
    repeat (3) @(negedge ck);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
